// File: rtl/fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_pkg : shared types and configuration check for the fifo_param block   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      OVF  = 2'd1,
      UDF  = 2'd2
   } fifo_err_t;

   typedef struct packed {
      logic empty;
      logic almost_empty;
      logic almost_full;
      logic full;
      logic valid;
   } fifo_status_t;

   // Depth must be a power of two so the pointers wrap naturally.
   function automatic bit fifo_cfg_ok(input int depth, input int ae, input int af);
      return (depth >= 4) && ((depth & (depth - 1)) == 0) && (ae < af) && (af <= depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// +----------------------------------------------------------------------------+
// | fifo_mem : DEPTH x DATA_W storage, synchronous write, asynchronous read    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/fifo_param.sv
// +----------------------------------------------------------------------------+
// | fifo_param : parametrised synchronous FIFO with thresholds, sticky errors  |
// |              and peak monitor. Define FIFO_FWFT_EN for first-word-fall-    |
// |              through read mode.                                            |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AE_LEVEL = 2,
   parameter int AF_LEVEL = DEPTH - 2,
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   input  logic              clr_stat,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow,
   output logic              ovf_sticky,
   output logic              udf_sticky,
   output logic [CNT_W-1:0]  count,
   output logic [CNT_W-1:0]  peak
);

   localparam int               PTR_W       = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_AE_LEVEL  = CNT_W'(AE_LEVEL);
   localparam logic [CNT_W-1:0] c_AF_LEVEL  = CNT_W'(AF_LEVEL);

   generate
      if (!fifo_cfg_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_cfg_bad
         $error("fifo_param: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL <= DEPTH");
      end
   endgenerate

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d, peak_q, peak_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic              ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
   logic              wr_acc, rd_acc, valid_w;
   logic [DATA_W-1:0] mem_rdata;
   fifo_err_t         err_d;
   fifo_status_t      stat;

   always_comb begin
      stat              = '0;
      stat.empty        = (count_q == '0);
      stat.full         = (count_q == c_DEPTH);
      stat.almost_empty = (count_q <= c_AE_LEVEL);
      stat.almost_full  = (count_q >= c_AF_LEVEL);
      stat.valid        = valid_w;
   end

   always_comb begin
      wr_acc   = wr_en && !stat.full;
      rd_acc   = rd_en && !stat.empty;
      wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      count_d = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Full and empty are mutually exclusive, so at most one error per cycle.
      err_d = NONE;
      if (wr_en && stat.full) begin
         err_d = OVF;
      end else if (rd_en && stat.empty) begin
         err_d = UDF;
      end

      ovf_d        = (err_d == OVF);
      udf_d        = (err_d == UDF);
      ovf_sticky_d = ovf_d || (ovf_sticky_q && !clr_stat);
      udf_sticky_d = udf_d || (udf_sticky_q && !clr_stat);

      if (clr_stat || (count_d > peak_q)) begin
         peak_d = count_d;
      end else begin
         peak_d = peak_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         peak_q       <= '0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
         udf_sticky_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         peak_q       <= peak_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
         ovf_sticky_q <= ovf_sticky_d;
         udf_sticky_q <= udf_sticky_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc && rst_n),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

`ifdef FIFO_FWFT_EN
   // Remember the last displayed word so data_out holds while empty.
   logic [DATA_W-1:0] hold_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (!stat.empty) begin
         hold_q <= mem_rdata;
      end
   end

   assign valid_w  = !stat.empty;
   assign data_out = stat.empty ? hold_q : mem_rdata;
`else
   logic [DATA_W-1:0] dout_q;
   logic              valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_acc;
         if (rd_acc) begin
            dout_q <= mem_rdata;
         end
      end
   end

   assign valid_w  = valid_q;
   assign data_out = dout_q;
`endif

   assign valid        = stat.valid;
   assign empty        = stat.empty;
   assign full         = stat.full;
   assign almost_empty = stat.almost_empty;
   assign almost_full  = stat.almost_full;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign ovf_sticky   = ovf_sticky_q;
   assign udf_sticky   = udf_sticky_q;
   assign count        = count_q;
   assign peak         = peak_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_param : directed self-checking bench for fifo_param (DEPTH=16)     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_param;

   logic       clk = 1'b0;
   logic       rst_n, wr_en, rd_en, clr_stat;
   logic [7:0] data_in, data_out;
   logic       valid, empty, full, almost_empty, almost_full;
   logic       overflow, underflow, ovf_sticky, udf_sticky;
   logic [4:0] count, peak;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] q [$];
   logic [7:0] exp_d;
   logic       w, r, wa, ra;
   int         max_cnt;

   fifo_param #(
      .DATA_W   (8),
      .DEPTH    (16),
      .AE_LEVEL (2),
      .AF_LEVEL (14)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .clr_stat     (clr_stat),
      .data_out     (data_out),
      .valid        (valid),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .underflow    (underflow),
      .ovf_sticky   (ovf_sticky),
      .udf_sticky   (udf_sticky),
      .count        (count),
      .peak         (peak)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      data_in = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic pop(input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
      check("pop_valid", 32'(valid), 32'd1);
      check("pop_data", 32'(data_out), 32'(exp));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
`else
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("pop_valid", 32'(valid), 32'd1);
      check("pop_data", 32'(data_out), 32'(exp));
`endif
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      clr_stat = 1'b0;
      data_in  = 8'h00;
      step();
      step();
      rst_n = 1'b1;

      check("rst_empty", 32'(empty), 32'd1);
      check("rst_aempty", 32'(almost_empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_afull", 32'(almost_full), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_peak", 32'(peak), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_dout", 32'(data_out), 32'd0);
      check("rst_errs", 32'({overflow, underflow, ovf_sticky, udf_sticky}), 32'd0);

      // Fill to full, checking thresholds at every occupancy.
      for (int i = 1; i <= 16; i++) begin
         push(8'(i));
         check("fill_count", 32'(count), 32'(i));
         check("fill_afull", 32'(almost_full), 32'(i >= 14));
         check("fill_aempty", 32'(almost_empty), 32'(i <= 2));
         check("fill_full", 32'(full), 32'(i == 16));
      end
      check("fill_peak", 32'(peak), 32'd16);

      // Full: read+write performs only the read and flags overflow.
`ifdef FIFO_FWFT_EN
      check("ovf_pre_data", 32'(data_out), 32'h01);
`endif
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      data_in = 8'hAA;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      check("ovf_count", 32'(count), 32'd15);
      check("ovf_pulse", 32'(overflow), 32'd1);
      check("ovf_sticky", 32'(ovf_sticky), 32'd1);
`ifndef FIFO_FWFT_EN
      check("ovf_data", 32'(data_out), 32'h01);
      check("ovf_valid", 32'(valid), 32'd1);
`endif
      step();
      check("ovf_pulse_end", 32'(overflow), 32'd0);
      check("ovf_sticky_hold", 32'(ovf_sticky), 32'd1);

      for (int i = 2; i <= 16; i++) begin
         pop(8'(i));
      end
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_count", 32'(count), 32'd0);

      // Empty: read flags underflow and leaves data_out alone.
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("udf_pulse", 32'(underflow), 32'd1);
      check("udf_sticky", 32'(udf_sticky), 32'd1);
      check("udf_data", 32'(data_out), 32'h10);
      check("udf_valid", 32'(valid), 32'd0);
      check("udf_count", 32'(count), 32'd0);
      step();
      check("udf_pulse_end", 32'(underflow), 32'd0);
      check("udf_sticky_hold", 32'(udf_sticky), 32'd1);
      clr_stat = 1'b1;
      step();
      clr_stat = 1'b0;
      check("clr_udf", 32'(udf_sticky), 32'd0);
      check("clr_ovf", 32'(ovf_sticky), 32'd0);
      check("clr_peak", 32'(peak), 32'd0);

      // Mixed traffic across pointer wrap against a reference queue.
      max_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         w = (i < 25) ? ((i % 4) != 3) : ((i % 3) == 0);
         r = (i < 25) ? ((i % 2) == 1) : 1'b1;
         wa = w && (q.size() < 16);
         ra = r && (q.size() > 0);
         wr_en   = w;
         rd_en   = r;
         data_in = 8'(8'h80 + i);
`ifdef FIFO_FWFT_EN
         if (q.size() > 0) check("mix_fwft_data", 32'(data_out), 32'(q[0]));
`endif
         exp_d = 8'h00;
         if (ra) exp_d = q.pop_front();
         if (wa) q.push_back(data_in);
         step();
`ifndef FIFO_FWFT_EN
         if (ra) check("mix_data", 32'(data_out), 32'(exp_d));
         check("mix_valid", 32'(valid), 32'(ra));
`endif
         check("mix_count", 32'(count), 32'(q.size()));
         if (q.size() > max_cnt) max_cnt = q.size();
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      check("mix_peak", 32'(peak), 32'(max_cnt));

      // Reset mid-operation discards queued words.
      for (int i = 0; i < 5; i++) begin
         push(8'(8'h60 + i));
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      q.delete();
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_empty", 32'(empty), 32'd1);
      check("mrst_valid", 32'(valid), 32'd0);
      check("mrst_peak", 32'(peak), 32'd0);
      push(8'h5C);
      pop(8'h5C);
      check("mrst_empty2", 32'(empty), 32'd1);

`ifdef FIFO_FWFT_EN
      push(8'h33);
      check("fwft_data", 32'(data_out), 32'h33);
      check("fwft_valid", 32'(valid), 32'd1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("fwft_empty", 32'(empty), 32'd1);
      check("fwft_valid_end", 32'(valid), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
